seq_detect_arbiter: RTL
=======================

# seq_detect_arbiter

Round-robin scheduler that shares one serial Mealy pattern detector among NCH requesting channels. Each granted channel's parallel word is serialized MSB-first into the detector. Overlapping pattern matches are counted, and a per-frame result is reported tagged with the channel number. The block sits between the parallel producers and the bit-serial detection datapath, and is the only driver of the detector's input and clear.

## Interface
- NCH, 4: number of requesting channels (≥2)
- WIDTH, 8: bits per frame
- PAT_LEN, 4: pattern length (2..WIDTH)
- PATTERN, 4'b1011: pattern, MSB is the first bit on the wire
- clk  in  1  single clock, rising edge
- clr  in  1  reset, synchronous, active-high
- req  in  NCH  per-channel request; held with data until granted
- data  in  NCH*WIDTH  channel i word at [i*WIDTH +: WIDTH]
- gnt  out  NCH  one-hot, one-cycle pulse on the cycle data is captured
- busy  out  1  high from the grant cycle through the done cycle
- done  out  1  one-cycle pulse, frame result valid
- done_ch  out  $clog2(NCH)  channel of the reported frame
- hit  out  1  reported frame contained ≥1 match
- hit_count  out  $clog2(WIDTH+1)  number of matches in the reported frame, overlaps included

## Operation
- FSM states: IDLE, SHIFT, REPORT.
- IDLE, with any req high:
  - Round-robin pick: first requesting channel after last_gnt, wrapping.
  - Pulse gnt for that channel; latch data into the shift register; latch the channel index.
  - Assert detector clear; zero the bit counter and the match accumulator.
  - Go to SHIFT.
- IDLE, with no req: stay in IDLE; gnt stays 0.
- SHIFT, WIDTH cycles:
  - Detector x = shift register MSB.
  - Sample detector y in the same cycle; it is Mealy and combinational on x and state. If y is high, increment the accumulator.
  - Shift left and increment the bit counter.
  - After bit WIDTH-1, go to REPORT.
- REPORT:
  - Pulse done.
  - Load done_ch, hit_count, and hit (= accumulator ≠ 0).
  - Update last_gnt.
  - Go to IDLE.
- done_ch, hit and hit_count hold their values until the next done.
- Detector behaviour:
  - y is high when the last PAT_LEN bits, including the current x, equal PATTERN.
  - Overlapping matches are detected.
  - Detector state is cleared at every grant, so matches never span frames.
- Requests:
  - req dropped before grant: no grant is issued and no error is raised.
  - req may stay high after grant; this counts as a fresh request and is arbitrated normally.
  - data changes after the grant cycle are ignored.
- Reset values (clr sampled high):
  - State IDLE; last_gnt = NCH-1, so channel 0 has first priority.
  - gnt = 0, busy = 0, done = 0, done_ch = 0, hit = 0, hit_count = 0.
  - Shift register, counter and accumulator = 0; detector cleared.
- clr mid-frame: the frame is discarded, no done is issued, and the next grant starts clean.

## Timing
- Grant at cycle 0; bits on cycles 1..WIDTH; done at cycle WIDTH+1.
- Next grant no earlier than cycle WIDTH+2, so one frame per WIDTH+2 cycles.
- gnt, done and all result outputs are registered.
- The detector's y path is combinational into the accumulator's increment enable only.
- Round robin is starvation-free: a channel with req held is granted within NCH frames.

## Structure
- Shared package seq_detect_pkg holds:
  - FSM state encoding localparams (IDLE, SHIFT, REPORT).
  - Default PAT_LEN and PATTERN.
- One sub-module: pattern_mealy.
  - Parameters: PAT_LEN, PATTERN.
  - Ports: clk, clr (sync), x, y.
  - Prefix-match state register of width $clog2(PAT_LEN+1).
- The arbiter owns the round-robin pointer, the FSM, the shift register, the bit counter and the accumulator.

## Test plan
All scenarios use defaults: NCH=4, WIDTH=8, PATTERN=4'b1011.
- Single frame: ch0 data 8'b1011_0000 → gnt[0] at cycle 0, done at cycle 9, done_ch=0, hit=1, hit_count=1.
- Overlap: ch2 data 8'b1011_0110 → done_ch=2, hit_count=2, from matches ending at bits 3 and 6.
- No match: ch1 data 8'hFF → hit=0, hit_count=0.
- Fairness: all four req held from cycle 0 → grants to 0,1,2,3 spaced 10 cycles apart, then 0 again; no channel skipped.
- Frame isolation: ch0 8'b0000_0101 then ch1 8'b1000_0000 → both report hit_count=0; the cross-frame "1011" is not detected.
- Reset mid-frame: clr high at cycle 4 of SHIFT → no done; all outputs at reset values next cycle. A following ch3 frame 8'b1011_1011 reports hit_count=2.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the round-robin serial pattern detector:
// FSM encoding and the default pattern.
package seq_detect_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_SHIFT  = SHIFT,
        ST_REPORT = REPORT
    } state_e;

    localparam int                     DEF_PAT_LEN = 4;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1011;

endpackage

// File: rtl/pattern_mealy.sv
// Mealy overlapping-pattern detector. State is the length of the longest
// pattern prefix that ends at the most recent bit.
module pattern_mealy
    import seq_detect_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic clr,
    input  logic x,
    output logic y
);

    localparam int SW = $clog2(PAT_LEN + 1);
    localparam int NS = 1 << SW;

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic [SW-1:0] nxt0 [NS];
    logic [SW-1:0] nxt1 [NS];

    // Longest prefix that is a suffix of (prefix(s) followed by xb).
    function automatic int step(input int s, input logic xb);
        logic [PAT_LEN:0] h;
        int               best;
        logic             ok;
        h    = '0;
        h[0] = xb;
        for (int j = 1; j <= PAT_LEN; j++) begin
            if (j <= s) h[j] = PATTERN[PAT_LEN - 1 - s + j];
        end
        best = 0;
        for (int k = 1; k <= PAT_LEN; k++) begin
            if (k <= s + 1) begin
                ok = 1'b1;
                for (int j = 0; j < PAT_LEN; j++) begin
                    if (j < k && h[j] != PATTERN[PAT_LEN - k + j]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_tab
            if (gi <= PAT_LEN) begin : g_live
                assign nxt0[gi] = SW'(step(gi, 1'b0));
                assign nxt1[gi] = SW'(step(gi, 1'b1));
            end else begin : g_dead
                assign nxt0[gi] = '0;
                assign nxt1[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        state_d = x ? nxt1[state_q] : nxt0[state_q];
        y       = (state_d == SW'(PAT_LEN));
    end

    always_ff @(posedge clk) begin
        if (clr) state_q <= '0;
        else     state_q <= state_d;
    end

endmodule

// File: rtl/seq_detect_arbiter.sv
// Round-robin arbiter that serializes one granted channel word at a time
// through a shared Mealy detector and reports the per-frame match count.
module seq_detect_arbiter
    import seq_detect_pkg::*;
#(
    parameter int                 NCH     = 4,
    parameter int                 WIDTH   = 8,
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [NCH-1:0]             req,
    input  logic [NCH*WIDTH-1:0]       data,
    output logic [NCH-1:0]             gnt,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NCH)-1:0]     done_ch,
    output logic                       hit,
    output logic [$clog2(WIDTH+1)-1:0] hit_count
);

    localparam int CW = $clog2(NCH);
    localparam int HW = $clog2(WIDTH + 1);
    localparam int BW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    last_gnt_q, last_gnt_d;
    logic [CW-1:0]    ch_q, ch_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic [HW-1:0]    acc_q, acc_d;
    logic [NCH-1:0]   gnt_q, gnt_d;
    logic             done_q, done_d;
    logic [CW-1:0]    done_ch_q, done_ch_d;
    logic             hit_q, hit_d;
    logic [HW-1:0]    hit_count_q, hit_count_d;

    logic [WIDTH-1:0] word [NCH];
    logic             pick_vld;
    logic [CW-1:0]    pick_idx;
    logic [CW:0]      rr_idx;
    logic             det_start;
    logic             det_clr;
    logic             det_x;
    logic             det_y;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_word
            assign word[gi] = data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        rr_idx   = '0;
        for (int off = NCH; off >= 1; off--) begin
            rr_idx = {1'b0, last_gnt_q} + (CW+1)'(off);
            if (rr_idx >= (CW+1)'(NCH)) rr_idx = rr_idx - (CW+1)'(NCH);
            if (req[rr_idx[CW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = rr_idx[CW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        ch_d        = ch_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        gnt_d       = '0;
        done_d      = 1'b0;
        done_ch_d   = done_ch_q;
        hit_d       = hit_q;
        hit_count_d = hit_count_q;
        det_start   = 1'b0;
        det_x       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_d     = NCH'(1) << pick_idx;
                    sreg_d    = word[pick_idx];
                    ch_d      = pick_idx;
                    cnt_d     = '0;
                    acc_d     = '0;
                    det_start = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                det_x  = sreg_q[WIDTH-1];
                if (det_y) acc_d = acc_q + HW'(1);
                sreg_d = sreg_q << 1;
                cnt_d  = cnt_q + BW'(1);
                if (cnt_q == BW'(WIDTH - 1)) state_d = ST_REPORT;
            end
            ST_REPORT: begin
                done_d      = 1'b1;
                done_ch_d   = ch_q;
                hit_count_d = acc_q;
                hit_d       = (acc_q != '0);
                last_gnt_d  = ch_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= CW'(NCH - 1);
            ch_q        <= '0;
            sreg_q      <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            gnt_q       <= '0;
            done_q      <= 1'b0;
            done_ch_q   <= '0;
            hit_q       <= 1'b0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            ch_q        <= ch_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            done_ch_q   <= done_ch_d;
            hit_q       <= hit_d;
            hit_count_q <= hit_count_d;
        end
    end

    // Clearing on every grant keeps matches from spanning frames.
    assign det_clr = clr | det_start;

    pattern_mealy #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_det (
        .clk (clk),
        .clr (det_clr),
        .x   (det_x),
        .y   (det_y)
    );

    assign gnt       = gnt_q;
    assign busy      = (state_q != ST_IDLE) | done_q;
    assign done      = done_q;
    assign done_ch   = done_ch_q;
    assign hit       = hit_q;
    assign hit_count = hit_count_q;

endmodule
